// File: rtl/odd_seq_pkg.sv
// odd_seq_pkg: shared definitions for the odd-counter link.
// State encoding and defaults common to sender and checker.
package odd_seq_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_STEP  = 2;
  localparam int RST_EXP   = 1;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter.
// A clear in the same cycle as an increment leaves the count at one.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] base;
  logic [W-1:0] nxt;

  // clear first, then increment unless saturated
  always_comb begin
    base = clr ? '0 : cnt_o;
    nxt  = base;
    if (inc && (base != '1))
      nxt = base + W'(1);
  end

  // count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_o <= '0;
    else
      cnt_o <= nxt;
  end

endmodule

// File: rtl/odd_seq_checker.sv
// odd_seq_checker: locks onto the 1,3,5,... counter stream
// and reports breaks, even samples and an error count.
module odd_seq_checker
  import odd_seq_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int STEP     = DEF_STEP,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic             err_o,
  output logic             parity_err_o,
  output logic             sticky_err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [WIDTH-1:0] exp_o
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] exp_d;
  logic [WIDTH-1:0] nxt_exp;
  logic [3:0]       mcnt_q;
  logic [3:0]       mcnt_d;
  logic [3:0]       mcnt_inc;
  logic             err_d;
  logic             par_d;
  logic             sticky_d;
  logic             odd;
  logic             hit;

  // next state, expected value, run length and error pulses
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_o;
    mcnt_d   = mcnt_q;
    err_d    = 1'b0;
    par_d    = 1'b0;
    odd      = cnt_i[0];
    hit      = (cnt_i == exp_o);
    nxt_exp  = cnt_i + WIDTH'(STEP);
    mcnt_inc = mcnt_q + 4'd1;
    if (valid_i) begin
      par_d = ~odd;
      case (state_q)
        SEARCH: begin
          if (odd) begin
            exp_d   = nxt_exp;
            mcnt_d  = 4'd1;
            state_d = LOCKING;
          end
        end
        LOCKING: begin
          if (hit) begin
            exp_d  = nxt_exp;
            mcnt_d = mcnt_inc;
            if (mcnt_inc == 4'(LOCK_CNT))
              state_d = LOCKED;
          end else if (odd) begin
            exp_d  = nxt_exp;
            mcnt_d = 4'd1;
          end else begin
            mcnt_d  = 4'd0;
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          if (hit) begin
            exp_d = nxt_exp;
          end else begin
            err_d = 1'b1;
            if (odd) begin
              exp_d   = nxt_exp;
              mcnt_d  = 4'd1;
              state_d = LOCKING;
            end else begin
              mcnt_d  = 4'd0;
              state_d = SEARCH;
            end
          end
        end
        default: begin
          mcnt_d  = 4'd0;
          state_d = SEARCH;
        end
      endcase
    end
    sticky_d = (clr_i ? 1'b0 : sticky_err_o) | err_d;
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= SEARCH;
      exp_o        <= WIDTH'(RST_EXP);
      mcnt_q       <= 4'd0;
      err_o        <= 1'b0;
      parity_err_o <= 1'b0;
      sticky_err_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_o        <= exp_d;
      mcnt_q       <= mcnt_d;
      err_o        <= err_d;
      parity_err_o <= par_d;
      sticky_err_o <= sticky_d;
    end
  end

  assign locked_o = (state_q == LOCKED);

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_i),
    .inc  (err_d),
    .cnt_o(err_cnt_o)
  );

endmodule

// File: tb/tb_odd_seq_checker.sv
// tb_odd_seq_checker: vector table plus scoreboard
// for the odd-sequence checker.
module tb_odd_seq_checker;

  typedef struct {
    logic       l;
    logic       e;
    logic       p;
    logic       s;
    logic [7:0] n;
    logic [7:0] x;
  } exp_t;

  typedef struct {
    logic       v;
    logic [7:0] c;
    logic       clr;
    exp_t       r;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid_i = 1'b0;
  logic [7:0] cnt_i = 8'd0;
  logic       clr_i = 1'b0;
  logic       locked_o;
  logic       err_o;
  logic       parity_err_o;
  logic       sticky_err_o;
  logic [7:0] err_cnt_o;
  logic [7:0] exp_o;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t tbl[$];

  odd_seq_checker dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .cnt_i       (cnt_i),
    .clr_i       (clr_i),
    .locked_o    (locked_o),
    .err_o       (err_o),
    .parity_err_o(parity_err_o),
    .sticky_err_o(sticky_err_o),
    .err_cnt_o   (err_cnt_o),
    .exp_o       (exp_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk_e(logic l, logic e, logic p,
                                logic s, logic [7:0] n,
                                logic [7:0] x);
    exp_t r;
    r.l = l; r.e = e; r.p = p;
    r.s = s; r.n = n; r.x = x;
    return r;
  endfunction

  function automatic vec_t mk(logic v, logic [7:0] c, logic clr,
                              logic l, logic e, logic p, logic s,
                              logic [7:0] n, logic [7:0] x);
    vec_t t;
    t.v = v; t.c = c; t.clr = clr;
    t.r = mk_e(l, e, p, s, n, x);
    return t;
  endfunction

  task automatic cmp(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic check_out(string tag, exp_t r);
    cmp({tag, " locked"}, locked_o, r.l);
    cmp({tag, " err"}, err_o, r.e);
    cmp({tag, " parity"}, parity_err_o, r.p);
    cmp({tag, " sticky"}, sticky_err_o, r.s);
    cmp({tag, " err_cnt"}, err_cnt_o, r.n);
    cmp({tag, " exp"}, exp_o, r.x);
  endtask

  task automatic apply(string tag, vec_t t);
    exp_t r;
    @(negedge clk);
    valid_i = t.v;
    cnt_i   = t.c;
    clr_i   = t.clr;
    sb.push_back(t.r);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      cmp({tag, " scoreboard empty"}, 0, 1);
    end else begin
      r = sb.pop_front();
      check_out(tag, r);
    end
  endtask

  initial begin
    logic [7:0] e;
    logic [7:0] x;
    int         n;

    // lock, break/relock, gaps, wrap, parity, clear+break
    tbl.push_back(mk(1,   1, 0, 0,0,0,0,0,  3));
    tbl.push_back(mk(1,   3, 0, 0,0,0,0,0,  5));
    tbl.push_back(mk(1,   5, 0, 0,0,0,0,0,  7));
    tbl.push_back(mk(1,   7, 0, 1,0,0,0,0,  9));
    tbl.push_back(mk(1,   9, 0, 1,0,0,0,0, 11));
    tbl.push_back(mk(1,  13, 0, 0,1,0,1,1, 15));
    tbl.push_back(mk(1,  15, 0, 0,0,0,1,1, 17));
    tbl.push_back(mk(1,  17, 0, 0,0,0,1,1, 19));
    tbl.push_back(mk(1,  19, 0, 1,0,0,1,1, 21));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, 8'h5a, 0, 1,0,0,1,1, 21));
    tbl.push_back(mk(1,  21, 0, 1,0,0,1,1, 23));
    tbl.push_back(mk(0,   0, 1, 1,0,0,0,0, 23));
    tbl.push_back(mk(1, 247, 0, 0,1,0,1,1,249));
    tbl.push_back(mk(1, 249, 0, 0,0,0,1,1,251));
    tbl.push_back(mk(1, 251, 0, 0,0,0,1,1,253));
    tbl.push_back(mk(1, 253, 0, 1,0,0,1,1,255));
    tbl.push_back(mk(1, 255, 0, 1,0,0,1,1,  1));
    tbl.push_back(mk(1,   1, 0, 1,0,0,1,1,  3));
    tbl.push_back(mk(1,   3, 0, 1,0,0,1,1,  5));
    tbl.push_back(mk(0,   0, 1, 1,0,0,0,0,  5));
    tbl.push_back(mk(1,   4, 0, 0,1,1,1,1,  5));
    tbl.push_back(mk(1,   1, 0, 0,0,0,1,1,  3));
    tbl.push_back(mk(1,   4, 0, 0,0,1,1,1,  3));
    tbl.push_back(mk(1,   5, 0, 0,0,0,1,1,  7));
    tbl.push_back(mk(1,   6, 0, 0,0,1,1,1,  7));
    tbl.push_back(mk(1,   8, 0, 0,0,1,1,1,  7));
    tbl.push_back(mk(1,   9, 0, 0,0,0,1,1, 11));
    tbl.push_back(mk(1,  11, 0, 0,0,0,1,1, 13));
    tbl.push_back(mk(0,   0, 0, 0,0,0,1,1, 13));
    tbl.push_back(mk(1,  13, 0, 0,0,0,1,1, 15));
    tbl.push_back(mk(1,  15, 0, 1,0,0,1,1, 17));
    tbl.push_back(mk(1,  20, 1, 0,1,1,1,1, 17));

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", mk_e(0,0,0,0,0,1));
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i])
      apply($sformatf("vec%0d", i), tbl[i]);

    // fresh run, then drive the error count into saturation
    @(negedge clk);
    valid_i = 1'b0;
    clr_i   = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    apply("sat pre1", mk(1, 1, 0, 0,0,0,0,0, 3));
    apply("sat pre3", mk(1, 3, 0, 0,0,0,0,0, 5));
    apply("sat pre5", mk(1, 5, 0, 0,0,0,0,0, 7));
    apply("sat pre7", mk(1, 7, 0, 1,0,0,0,0, 9));
    e = 8'd9;
    for (int i = 1; i <= 256; i++) begin
      x = e + 8'd2;
      n = (i > 255) ? 255 : i;
      apply($sformatf("sat brk%0d", i),
            mk(1, x, 0, 0,1,0,1,8'(n), x + 8'd2));
      apply($sformatf("sat r2_%0d", i),
            mk(1, x + 8'd2, 0, 0,0,0,1,8'(n), x + 8'd4));
      apply($sformatf("sat r3_%0d", i),
            mk(1, x + 8'd4, 0, 0,0,0,1,8'(n), x + 8'd6));
      apply($sformatf("sat r4_%0d", i),
            mk(1, x + 8'd6, 0, 1,0,0,1,8'(n), x + 8'd8));
      e = x + 8'd8;
    end
    x = e + 8'd2;
    apply("clr+brk", mk(1, x, 1, 0,1,0,1,1, x + 8'd2));
    apply("relock2", mk(1, x + 8'd2, 0, 0,0,0,1,1, x + 8'd4));
    apply("relock3", mk(1, x + 8'd4, 0, 0,0,0,1,1, x + 8'd6));
    apply("relock4", mk(1, x + 8'd6, 0, 1,0,0,1,1, x + 8'd8));

    // asynchronous reset in the middle of a locked stream
    @(negedge clk);
    valid_i = 1'b1;
    cnt_i   = x + 8'd8;
    clr_i   = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_out("midrst", mk_e(0,0,0,0,0,1));
    @(negedge clk);
    rst = 1'b1;
    apply("post rst1", mk(1, 1, 0, 0,0,0,0,0, 3));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/odd_seq_checker.md
# odd_seq_checker

Receive-side checker for the 8-bit odd-counter stream. Samples a counter value each valid cycle, locks onto the sequence 1, 3, 5, … (step 2, modulo 2^WIDTH) after a run of consistent samples, then flags every break in the sequence. It sits at the consuming end of the counter link and reports lock status, error pulses and a saturating error count to status logic.

## Interface
- WIDTH, 8, width of the sampled counter value
- STEP, 2, expected increment between consecutive valid samples (modulo 2^WIDTH)
- LOCK_CNT, 4, consecutive consistent samples required to declare lock (range 2..15)
- ERR_W, 8, width of the error counter
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- valid_i  input  1  cnt_i carries a sample this cycle
- cnt_i  input  WIDTH  sampled counter value
- clr_i  input  1  synchronous clear of err_cnt_o and sticky_err_o
- locked_o  output  1  sequence locked
- err_o  output  1  one-cycle pulse: sequence break detected while locked
- parity_err_o  output  1  one-cycle pulse: even sample received (LSB = 0)
- sticky_err_o  output  1  set by any err_o event, held until clr_i or reset
- err_cnt_o  output  ERR_W  count of err_o events, saturating at all-ones
- exp_o  output  WIDTH  next expected sample value

## Operation
- States: SEARCH, LOCKING, LOCKED. Only cycles with valid_i = 1 advance the FSM, the expected value or the match count. valid_i = 0 cycles change nothing except clr_i effects.
- Match: cnt_i == exp_o. On match, exp_o <= cnt_i + STEP, truncated to WIDTH bits. Wrap example: 255 + 2 gives 1.
- Sample is odd when cnt_i[0] = 1. Any valid even sample pulses parity_err_o, in every state.
- SEARCH, valid odd sample: exp_o <= cnt_i + STEP, match_cnt <= 1, next state LOCKING.
- SEARCH, valid even sample: stay in SEARCH.
- LOCKING, match: match_cnt increments. When it reaches LOCK_CNT, next state LOCKED.
- LOCKING, mismatch with odd sample: restart the run. exp_o <= cnt_i + STEP, match_cnt <= 1, stay in LOCKING. No err_o.
- LOCKING, mismatch with even sample: next state SEARCH.
- LOCKED, match: advance exp_o and stay in LOCKED.
- LOCKED, mismatch: pulse err_o, set sticky_err_o, increment err_cnt_o unless it is saturated, drop locked_o.
  - Odd sample: resync as in the LOCKING restart (match_cnt = 1, state LOCKING).
  - Even sample: next state SEARCH.
- locked_o = 1 exactly when the state is LOCKED.
- clr_i and an err_o event in the same cycle: the clear applies first, then the event. Result: err_cnt_o = 1, sticky_err_o = 1.
- Reset values:
  - state SEARCH, match_cnt 0
  - locked_o 0, err_o 0, parity_err_o 0, sticky_err_o 0, err_cnt_o 0
  - exp_o = 1, the counter's reset value
- Assertion of rst mid-stream returns all of the above to reset values immediately. The run restarts from SEARCH after release.

## Timing
- All outputs are registered. A sample taken at edge N is reflected in the outputs after edge N; there is no combinational path from input to output.
- err_o and parity_err_o are high for exactly the one cycle after the offending sample edge.
- Lock latency: locked_o rises after the edge of the LOCK_CNT-th consecutive consistent sample, counting the first odd sample as 1. With defaults, samples 1, 3, 5, 7 on edges 1–4 give locked_o = 1 after edge 4.
- Gaps in valid_i do not affect lock or the match run.
- The first valid sample after reset release is accepted on the first rising edge with rst high.

## Structure
- Shared package odd_seq_pkg holds:
  - state encoding: SEARCH = 2'd0, LOCKING = 2'd1, LOCKED = 2'd2
  - default WIDTH, STEP and reset expected value 1, shared with the counter side
- One natural sub-module: sat_counter (ERR_W-bit, with inc, clr and clear-then-increment priority). It implements err_cnt_o.
- FSM, expected-value register and match counter stay in the top module.

## Test plan
- Reset, then valid samples 1, 3, 5, 7, 9: locked_o rises after the 4th sample and stays high. err_o is never high, exp_o = 11 at the end.
- Locked stream reaching 253, 255, 1, 3: wrap is accepted, locked_o stays 1, err_cnt_o stays 0.
- Locked, then samples 9, 13, 15, 17, 19: err_o pulses once after 13, locked_o drops, err_cnt_o = 1, sticky_err_o = 1. Relock occurs after 19 (13 is run sample 1).
- Samples 1, 4, 5: parity_err_o pulses after 4, state returns to SEARCH. 5 starts a new run with exp_o = 7.
- err_cnt_o preloaded to 255 by repeated breaks, then another break: err_cnt_o stays 255, err_o still pulses. clr_i together with a break gives err_cnt_o = 1.
- Locked, valid_i held low for 10 cycles, then the next expected value: still locked, no error. rst pulsed low mid-stream: all outputs return to reset values, exp_o = 1.
